// File: rtl/arm_pkg.sv
// Shared ARM core definitions: datapath widths, ALU execute-command codes and the
// ID/EXE pipeline bundle.
package arm_pkg;

  localparam int unsigned DATA_WIDTH     = 32;
  localparam int unsigned REG_ADDR_WIDTH = 4;
  localparam int unsigned CMD_WIDTH      = 4;

  // ALU execute-command encodings. CMP/TST and LDR/STR reuse the SUB/AND/ADD codes.
  localparam logic [CMD_WIDTH-1:0] EXE_MOV = 4'b0001;
  localparam logic [CMD_WIDTH-1:0] EXE_MVN = 4'b1001;
  localparam logic [CMD_WIDTH-1:0] EXE_ADD = 4'b0010;
  localparam logic [CMD_WIDTH-1:0] EXE_ADC = 4'b0011;
  localparam logic [CMD_WIDTH-1:0] EXE_SUB = 4'b0100;
  localparam logic [CMD_WIDTH-1:0] EXE_SBC = 4'b0101;
  localparam logic [CMD_WIDTH-1:0] EXE_AND = 4'b0110;
  localparam logic [CMD_WIDTH-1:0] EXE_ORR = 4'b0111;
  localparam logic [CMD_WIDTH-1:0] EXE_EOR = 4'b1000;
  localparam logic [CMD_WIDTH-1:0] EXE_CMP = 4'b0100;
  localparam logic [CMD_WIDTH-1:0] EXE_TST = 4'b0110;
  localparam logic [CMD_WIDTH-1:0] EXE_LDR = 4'b0010;
  localparam logic [CMD_WIDTH-1:0] EXE_STR = 4'b0010;

  typedef struct packed {
    logic                      valid;
    logic                      wb_en;
    logic                      mem_r_en;
    logic                      mem_w_en;
    logic                      mem_en;
    logic                      b;
    logic                      s;
    logic [CMD_WIDTH-1:0]      exe_cmd;
    logic [DATA_WIDTH-1:0]     pc;
    logic [DATA_WIDTH-1:0]     val_rn;
    logic [DATA_WIDTH-1:0]     val_rm;
    logic                      imm;
    logic [11:0]               shift_operand;
    logic [23:0]               signed_imm24;
    logic [REG_ADDR_WIDTH-1:0] dest;
    logic [REG_ADDR_WIDTH-1:0] src1;
    logic [REG_ADDR_WIDTH-1:0] src2;
    logic                      status_c;
  } id_exe_bundle_t;

endpackage

// File: rtl/pipe_reg.sv
// Generic pipeline register: async active-high reset, synchronous clear (bubble)
// which takes priority over hold (stall).
module pipe_reg #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_hold,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (i_clear) begin
      r_q <= '0;
    end else if (!i_hold) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/id_exe_stage_reg.sv
// ID/EXE pipeline register of the 5-stage ARM core. Control bits are gated by
// id_valid before capture so an invalid ID slot never writes architectural state.
module id_exe_stage_reg #(
  parameter int unsigned DATA_WIDTH     = arm_pkg::DATA_WIDTH,
  parameter int unsigned REG_ADDR_WIDTH = arm_pkg::REG_ADDR_WIDTH,
  parameter int unsigned CMD_WIDTH      = arm_pkg::CMD_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      freeze,
  input  logic                      flush,
  input  logic                      id_valid,
  input  logic                      id_wb_en,
  input  logic                      id_mem_r_en,
  input  logic                      id_mem_w_en,
  input  logic                      id_b,
  input  logic                      id_s,
  input  logic [CMD_WIDTH-1:0]      id_exe_cmd,
  input  logic [DATA_WIDTH-1:0]     id_pc,
  input  logic [DATA_WIDTH-1:0]     id_val_rn,
  input  logic [DATA_WIDTH-1:0]     id_val_rm,
  input  logic                      id_imm,
  input  logic [11:0]               id_shift_operand,
  input  logic [23:0]               id_signed_imm24,
  input  logic [REG_ADDR_WIDTH-1:0] id_dest,
  input  logic [REG_ADDR_WIDTH-1:0] id_src1,
  input  logic [REG_ADDR_WIDTH-1:0] id_src2,
  input  logic                      id_status_c,
  output logic                      exe_valid,
  output logic                      exe_wb_en,
  output logic                      exe_mem_r_en,
  output logic                      exe_mem_w_en,
  output logic                      exe_mem_en,
  output logic                      exe_b,
  output logic                      exe_s,
  output logic [CMD_WIDTH-1:0]      exe_exe_cmd,
  output logic [DATA_WIDTH-1:0]     exe_pc,
  output logic [DATA_WIDTH-1:0]     exe_val_rn,
  output logic [DATA_WIDTH-1:0]     exe_val_rm,
  output logic                      exe_imm,
  output logic [11:0]               exe_shift_operand,
  output logic [23:0]               exe_signed_imm24,
  output logic [REG_ADDR_WIDTH-1:0] exe_dest,
  output logic [REG_ADDR_WIDTH-1:0] exe_src1,
  output logic [REG_ADDR_WIDTH-1:0] exe_src2,
  output logic                      exe_status_c
);

  import arm_pkg::*;

  id_exe_bundle_t w_d;
  id_exe_bundle_t w_q;

  always_comb begin
    w_d               = '0;
    w_d.valid         = id_valid;
    w_d.wb_en         = id_valid & id_wb_en;
    w_d.mem_r_en      = id_valid & id_mem_r_en;
    w_d.mem_w_en      = id_valid & id_mem_w_en;
    w_d.b             = id_valid & id_b;
    w_d.s             = id_valid & id_s;
    // Registered so the Val2 generator sees a flop output, not extra logic.
    w_d.mem_en        = w_d.mem_r_en | w_d.mem_w_en;
    w_d.exe_cmd       = id_exe_cmd;
    w_d.pc            = id_pc;
    w_d.val_rn        = id_val_rn;
    w_d.val_rm        = id_val_rm;
    w_d.imm           = id_imm;
    w_d.shift_operand = id_shift_operand;
    w_d.signed_imm24  = id_signed_imm24;
    w_d.dest          = id_dest;
    w_d.src1          = id_src1;
    w_d.src2          = id_src2;
    w_d.status_c      = id_status_c;
  end

  pipe_reg #(
    .WIDTH($bits(id_exe_bundle_t))
  ) u_pipe_reg (
    .clk    (clk),
    .rst    (rst),
    .i_clear(flush),
    .i_hold (freeze),
    .i_d    (w_d),
    .o_q    (w_q)
  );

  assign exe_valid         = w_q.valid;
  assign exe_wb_en         = w_q.wb_en;
  assign exe_mem_r_en      = w_q.mem_r_en;
  assign exe_mem_w_en      = w_q.mem_w_en;
  assign exe_mem_en        = w_q.mem_en;
  assign exe_b             = w_q.b;
  assign exe_s             = w_q.s;
  assign exe_exe_cmd       = w_q.exe_cmd;
  assign exe_pc            = w_q.pc;
  assign exe_val_rn        = w_q.val_rn;
  assign exe_val_rm        = w_q.val_rm;
  assign exe_imm           = w_q.imm;
  assign exe_shift_operand = w_q.shift_operand;
  assign exe_signed_imm24  = w_q.signed_imm24;
  assign exe_dest          = w_q.dest;
  assign exe_src1          = w_q.src1;
  assign exe_src2          = w_q.src2;
  assign exe_status_c      = w_q.status_c;

endmodule

// File: tb/tb_id_exe_stage_reg.sv
// Directed bench for id_exe_stage_reg: expected bundles are queued when stimulus is
// driven and popped/compared one edge later.
module tb_id_exe_stage_reg;
  import arm_pkg::*;

  logic clk = 1'b0;
  logic rst, freeze, flush;
  logic id_valid, id_wb_en, id_mem_r_en, id_mem_w_en, id_b, id_s, id_imm, id_status_c;
  logic [CMD_WIDTH-1:0]      id_exe_cmd;
  logic [DATA_WIDTH-1:0]     id_pc, id_val_rn, id_val_rm;
  logic [11:0]               id_shift_operand;
  logic [23:0]               id_signed_imm24;
  logic [REG_ADDR_WIDTH-1:0] id_dest, id_src1, id_src2;

  logic exe_valid, exe_wb_en, exe_mem_r_en, exe_mem_w_en, exe_mem_en, exe_b, exe_s;
  logic exe_imm, exe_status_c;
  logic [CMD_WIDTH-1:0]      exe_exe_cmd;
  logic [DATA_WIDTH-1:0]     exe_pc, exe_val_rn, exe_val_rm;
  logic [11:0]               exe_shift_operand;
  logic [23:0]               exe_signed_imm24;
  logic [REG_ADDR_WIDTH-1:0] exe_dest, exe_src1, exe_src2;

  int n_chk  = 0;
  int n_fail = 0;
  id_exe_bundle_t q_exp[$];
  id_exe_bundle_t m_state;

  always #5 clk = ~clk;

  id_exe_stage_reg dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .id_valid(id_valid), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en),
    .id_mem_w_en(id_mem_w_en), .id_b(id_b), .id_s(id_s), .id_exe_cmd(id_exe_cmd),
    .id_pc(id_pc), .id_val_rn(id_val_rn), .id_val_rm(id_val_rm), .id_imm(id_imm),
    .id_shift_operand(id_shift_operand), .id_signed_imm24(id_signed_imm24),
    .id_dest(id_dest), .id_src1(id_src1), .id_src2(id_src2), .id_status_c(id_status_c),
    .exe_valid(exe_valid), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
    .exe_mem_w_en(exe_mem_w_en), .exe_mem_en(exe_mem_en), .exe_b(exe_b), .exe_s(exe_s),
    .exe_exe_cmd(exe_exe_cmd), .exe_pc(exe_pc), .exe_val_rn(exe_val_rn),
    .exe_val_rm(exe_val_rm), .exe_imm(exe_imm), .exe_shift_operand(exe_shift_operand),
    .exe_signed_imm24(exe_signed_imm24), .exe_dest(exe_dest), .exe_src1(exe_src1),
    .exe_src2(exe_src2), .exe_status_c(exe_status_c)
  );

  function automatic id_exe_bundle_t act();
    id_exe_bundle_t a;
    a = '{valid: exe_valid, wb_en: exe_wb_en, mem_r_en: exe_mem_r_en,
          mem_w_en: exe_mem_w_en, mem_en: exe_mem_en, b: exe_b, s: exe_s,
          exe_cmd: exe_exe_cmd, pc: exe_pc, val_rn: exe_val_rn, val_rm: exe_val_rm,
          imm: exe_imm, shift_operand: exe_shift_operand,
          signed_imm24: exe_signed_imm24, dest: exe_dest, src1: exe_src1,
          src2: exe_src2, status_c: exe_status_c};
    return a;
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_id();
    {id_valid, id_wb_en, id_mem_r_en, id_mem_w_en, id_b, id_s, id_imm, id_status_c} = '0;
    id_exe_cmd = '0; id_pc = '0; id_val_rn = '0; id_val_rm = '0;
    id_shift_operand = '0; id_signed_imm24 = '0; id_dest = '0; id_src1 = '0; id_src2 = '0;
  endtask

  task automatic rand_id();
    {id_valid, id_wb_en, id_mem_r_en, id_mem_w_en} = 4'($urandom);
    {id_b, id_s, id_imm, id_status_c} = 4'($urandom);
    id_exe_cmd = 4'($urandom); id_pc = $urandom; id_val_rn = $urandom; id_val_rm = $urandom;
    id_shift_operand = 12'($urandom); id_signed_imm24 = 24'($urandom);
    id_dest = 4'($urandom); id_src1 = 4'($urandom); id_src2 = 4'($urandom);
  endtask

  // One clock edge: queue the expected register contents, then compare after the edge.
  task automatic tick(input string tag);
    id_exe_bundle_t nxt;
    if (flush) begin
      nxt = '0;
    end else if (freeze) begin
      nxt = m_state;
    end else begin
      nxt = '{valid: id_valid, wb_en: id_valid && id_wb_en,
              mem_r_en: id_valid && id_mem_r_en, mem_w_en: id_valid && id_mem_w_en,
              mem_en: id_valid && (id_mem_r_en || id_mem_w_en),
              b: id_valid && id_b, s: id_valid && id_s, exe_cmd: id_exe_cmd, pc: id_pc,
              val_rn: id_val_rn, val_rm: id_val_rm, imm: id_imm,
              shift_operand: id_shift_operand, signed_imm24: id_signed_imm24,
              dest: id_dest, src1: id_src1, src2: id_src2, status_c: id_status_c};
    end
    q_exp.push_back(nxt);
    m_state = nxt;
    @(posedge clk);
    #1;
    check(tag, act(), q_exp.pop_front());
  endtask

  initial begin
    rst = 1'b1; freeze = 1'b0; flush = 1'b0;
    clear_id();
    m_state = '0;
    #2;
    check("reset_state", act(), '0);
    @(negedge clk);
    rst = 1'b0;

    // 1: async reset with loaded contents
    rand_id(); id_valid = 1'b1; id_mem_r_en = 1'b1;
    tick("pre_reset_load");
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_all", act(), '0);
    check("async_reset_mem_en", exe_mem_en, 1'b0);
    m_state = '0;
    @(negedge clk);
    rst = 1'b0;

    // 2: ADD R3,R1,R2
    clear_id();
    id_valid = 1'b1; id_wb_en = 1'b1; id_exe_cmd = EXE_ADD; id_val_rn = 32'h0000_0005;
    id_val_rm = 32'h0000_0007; id_dest = 4'd3; id_src1 = 4'd1; id_src2 = 4'd2;
    id_shift_operand = 12'h002; id_pc = 32'h0000_0008;
    tick("add_load");
    check("add_val_rn", exe_val_rn, 32'h5);
    check("add_val_rm", exe_val_rm, 32'h7);
    check("add_dest", exe_dest, 4'd3);
    check("add_cmd", exe_exe_cmd, 4'b0010);
    check("add_mem_en", exe_mem_en, 1'b0);

    // 3: STR then freeze for 3 edges with changing inputs
    clear_id();
    id_valid = 1'b1; id_mem_w_en = 1'b1; id_exe_cmd = EXE_STR; id_imm = 1'b0;
    id_shift_operand = 12'hFFC; id_val_rn = 32'h0000_1000; id_src2 = 4'd5;
    tick("str_load");
    check("str_mem_en", exe_mem_en, 1'b1);
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_id();
      tick("freeze_hold");
      check("freeze_shift", exe_shift_operand, 12'hFFC);
      check("freeze_mem_w", exe_mem_w_en, 1'b1);
      check("freeze_mem_en", exe_mem_en, 1'b1);
      check("freeze_val_rn", exe_val_rn, 32'h0000_1000);
    end

    // 4: flush wins over freeze
    flush = 1'b1; id_valid = 1'b1; id_wb_en = 1'b1;
    tick("flush_freeze");
    check("flush_valid", exe_valid, 1'b0);
    check("flush_wb_en", exe_wb_en, 1'b0);
    check("flush_b", exe_b, 1'b0);
    check("flush_mem_en", exe_mem_en, 1'b0);
    check("flush_all_zero", act(), '0);
    flush = 1'b0; freeze = 1'b0;

    // 5: invalid slot loads with control gated off
    rand_id();
    id_valid = 1'b0; id_wb_en = 1'b1; id_mem_r_en = 1'b1;
    tick("invalid_load");
    check("invalid_wb_en", exe_wb_en, 1'b0);
    check("invalid_mem_r", exe_mem_r_en, 1'b0);
    check("invalid_mem_en", exe_mem_en, 1'b0);

    // 6: B followed by flush
    clear_id();
    id_valid = 1'b1; id_b = 1'b1; id_signed_imm24 = 24'hFFFFFE; id_pc = 32'h0000_0010;
    tick("branch_load");
    check("branch_b", exe_b, 1'b1);
    check("branch_imm24", exe_signed_imm24, 24'hFFFFFE);
    check("branch_pc", exe_pc, 32'h0000_0010);
    flush = 1'b1;
    tick("branch_flush");
    check("branch_bubble", act(), '0);
    flush = 1'b0;

    // Reset asserted mid-freeze dominates; first edge afterwards obeys freeze
    rand_id(); id_valid = 1'b1;
    tick("pre_freeze_load");
    freeze = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check("reset_mid_freeze", act(), '0);
    m_state = '0;
    @(negedge clk);
    rst = 1'b0;
    rand_id();
    tick("post_reset_freeze");
    freeze = 1'b0;

    // Mixed random traffic
    for (int i = 0; i < 40; i++) begin
      rand_id();
      flush  = ($urandom_range(0, 4) == 0);
      freeze = ($urandom_range(0, 3) == 0);
      tick("random_step");
    end
    check("queue_drained", 256'(q_exp.size()), 256'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
